uart_top: RTL and testbench
===========================

UART_TOP -- requirements
Module: uart_top

Interface
REQ-001 SHALL have ports: i_clk  in  1  sole clock, rising edge.
REQ-002 SHALL have: i_rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: i_request_tx  in  1  transmit request, sampled on the rising edge.
REQ-004 SHALL have: i_ws_n  in  1  register write strobe, active-low.
REQ-005 SHALL have: i_rs_n  in  1  register read strobe, active-low.
REQ-006 SHALL have: i_addr  in  4  register address.
REQ-007 SHALL have: i_data  in  9  write data; bits [7:0] are also the TX byte.
REQ-008 SHALL have: o_data  out  9  registered read/RX data.
REQ-009 SHALL have: i_rx  in  1  serial input.
REQ-010 SHALL have: o_tx  out  1  serial output, idle high.
REQ-011 SHALL have: o_ready  out  1  transmitter idle.
REQ-012 SHALL have: o_rx_error  out  1  last received frame bad.
REQ-013 SHALL have: o_rx_valid  out  1  last received frame good.

Function
REQ-014 Registers SHALL be: 0x0 DIVL and 0x1 DIVH, forming the 16-bit clocks-per-bit value (reset 16, values below 4 treated as 4); 0x7 LCR, where bit3 = parity enable, bit1 = odd parity, bit0 = two stop bits (reset 0); other addresses read 0, and writes to them are ignored.
REQ-015 With i_ws_n=0 at a clock edge, i_data[7:0] SHALL be written to register i_addr.
REQ-016 With i_rs_n=0, o_data SHALL be loaded with {1'b0, reg[i_addr]} at the next edge.
REQ-017 TX FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-018 In IDLE, i_request_tx=1 SHALL latch i_data[7:0], DIV and LCR, and drop o_ready on the next edge.
REQ-019 A request SHALL be ignored when o_ready=0.
REQ-020 The frame SHALL be: start 0; 8 data bits LSB first; optional parity bit; 1 or 2 stop bits at 1. Each bit SHALL last exactly DIV clocks.
REQ-021 o_ready SHALL rise in the cycle after the last stop bit completes.
REQ-022 Register writes during a frame SHALL affect only later frames.
REQ-023 i_rx SHALL pass through a 2-flop synchronizer.
REQ-024 RX FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-025 A falling edge on the synchronized input SHALL enter START.
REQ-026 RX SHALL sample every bit at DIV/2 into the bit.
REQ-027 If start reads 1 at mid-bit, RX SHALL return to IDLE silently.
REQ-028 RX SHALL check only the first stop bit.
REQ-029 On good stop (and parity): o_data <= {1'b0, byte}, o_rx_valid=1, o_rx_error=0.
REQ-030 On stop=0 or parity mismatch: o_data <= {1'b1, byte}, o_rx_error=1, o_rx_valid=0.
REQ-031 o_rx_valid and o_rx_error SHALL be levels held until the next start bit is detected, then cleared.
REQ-032 When RX completion and a read fall in the same cycle, RX data SHALL win and the read is dropped.
REQ-033 TX and RX SHALL run independently and full-duplex; loopback (i_rx driven from o_tx) SHALL return every byte unchanged.

Reset
REQ-034 On i_rst_n=0, asynchronously: o_data=0, o_tx=1, o_ready=1, o_rx_error=0, o_rx_valid=0.
REQ-035 On reset, both FSMs SHALL go to IDLE and registers SHALL return to their reset values.
REQ-036 Reset mid-frame SHALL abort the frame with no partial output.
REQ-037 o_ready SHALL be 1 on the first edge after release.

Configuration
REQ-038 Macro UART_PARITY_EN defined: the PARITY states and LCR bits 3 and 1 SHALL be implemented.
REQ-039 Macro UART_PARITY_EN undefined: LCR bits 3 and 1 SHALL read 0 and be ignored, no parity bit SHALL be sent or checked, and o_rx_error SHALL flag framing errors only.

Verification
REQ-040 Reset: hold i_rst_n low 25 cycles, release -> o_data=0, o_tx=1, o_ready=1, o_rx_error=0, o_rx_valid=0.
REQ-041 Loopback: 5 random bytes, each sent with a 1-cycle request -> each returns in o_data with o_rx_valid=1 and o_rx_error=0.
REQ-042 Write LCR=0x09 (addr 7), loopback 0x5A -> frame is 12 bits, o_data=0x05A, no error (parity-enabled build); 0x05A and no error also in a build without UART_PARITY_EN.
REQ-043 Drive i_rx with stop bit 0 on byte 0x3C -> o_rx_error=1, o_data=0x13C.
REQ-044 Second request while busy with 0x11 -> only 0x11 is transmitted; frame duration = 10*DIV clocks.
REQ-045 Write DIVL=0x08, read addr 0 -> o_data=0x008; next frame uses 8 clocks/bit.

Source files
------------

// File: rtl/uart_top.sv
// uart_top: register-configured full-duplex UART.
// Registers: 0x0 DIVL, 0x1 DIVH (clocks per bit, minimum 4), 0x7 LCR
// (bit3 parity enable, bit1 odd parity, bit0 two stop bits).
// Optional parity support is compiled in when UART_PARITY_EN is defined;
// otherwise LCR bits 3 and 1 are forced to zero and no parity is sent or checked.
module uart_top (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_request_tx,
  input  logic       i_ws_n,
  input  logic       i_rs_n,
  input  logic [3:0] i_addr,
  input  logic [8:0] i_data,
  output logic [8:0] o_data,
  input  logic       i_rx,
  output logic       o_tx,
  output logic       o_ready,
  output logic       o_rx_error,
  output logic       o_rx_valid
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  localparam logic [15:0] MinDiv = 16'd4;

`ifdef UART_PARITY_EN
  localparam logic [7:0] LcrMask = 8'hFF;
`else
  // Parity enable and odd-parity bits do not exist in this build.
  localparam logic [7:0] LcrMask = 8'hF5;
`endif

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  logic [7:0]  divl_q, divh_q, lcr_q;
  logic [15:0] div_raw, div_eff;
  logic [7:0]  reg_rd;
  logic        unused_data_bit;

  assign unused_data_bit = i_data[8];

  // Register writes; unknown addresses are ignored.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      divl_q <= 8'h10;
      divh_q <= 8'h00;
      lcr_q  <= 8'h00;
    end else if (!i_ws_n) begin
      case (i_addr)
        4'h0:    divl_q <= i_data[7:0];
        4'h1:    divh_q <= i_data[7:0];
        4'h7:    lcr_q  <= i_data[7:0] & LcrMask;
        default: ;
      endcase
    end
  end

  // Effective divider is clamped so a bit always spans at least 4 clocks.
  always_comb begin
    div_raw = {divh_q, divl_q};
    div_eff = (div_raw < MinDiv) ? MinDiv : div_raw;
  end

  // Register read mux.
  always_comb begin
    reg_rd = 8'h00;
    case (i_addr)
      4'h0:    reg_rd = divl_q;
      4'h1:    reg_rd = divh_q;
      4'h7:    reg_rd = lcr_q;
      default: reg_rd = 8'h00;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  logic [2:0]  tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [15:0] tx_div_q, tx_div_d;
  logic        tx_par_en_q, tx_par_en_d;
  logic        tx_odd_q, tx_odd_d;
  logic        tx_two_q, tx_two_d;
  logic        tx_stop2_q, tx_stop2_d;
  logic        tx_line_q, tx_line_d;
  logic        ready_q, ready_d;
  logic [15:0] tx_last;

  assign tx_last = tx_div_q - 16'd1;

  // TX next state: frame settings are frozen at request time.
  always_comb begin
    tx_state_d  = tx_state_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_byte_d   = tx_byte_q;
    tx_div_d    = tx_div_q;
    tx_par_en_d = tx_par_en_q;
    tx_odd_d    = tx_odd_q;
    tx_two_d    = tx_two_q;
    tx_stop2_d  = tx_stop2_q;
    tx_line_d   = tx_line_q;
    ready_d     = ready_q;
    if (tx_state_q == StIdle) begin
      if (i_request_tx) begin
        tx_state_d  = StStart;
        tx_cnt_d    = 16'd0;
        tx_byte_d   = i_data[7:0];
        tx_div_d    = div_eff;
        tx_par_en_d = lcr_q[3];
        tx_odd_d    = lcr_q[1];
        tx_two_d    = lcr_q[0];
        tx_line_d   = 1'b0;
        ready_d     = 1'b0;
      end
    end else if (tx_cnt_q != tx_last) begin
      tx_cnt_d = tx_cnt_q + 16'd1;
    end else begin
      tx_cnt_d = 16'd0;
      case (tx_state_q)
        StStart: begin
          tx_state_d = StData;
          tx_bit_d   = 3'd0;
          tx_line_d  = tx_byte_q[0];
        end
        StData: begin
          if (tx_bit_q != 3'd7) begin
            tx_bit_d  = tx_bit_q + 3'd1;
            tx_line_d = tx_byte_q[tx_bit_q + 3'd1];
          end else if (tx_par_en_q) begin
            tx_state_d = StParity;
            tx_line_d  = ^tx_byte_q ^ tx_odd_q;
          end else begin
            tx_state_d = StStop;
            tx_stop2_d = 1'b0;
            tx_line_d  = 1'b1;
          end
        end
        StParity: begin
          tx_state_d = StStop;
          tx_stop2_d = 1'b0;
          tx_line_d  = 1'b1;
        end
        StStop: begin
          if (tx_two_q && !tx_stop2_q) begin
            tx_stop2_d = 1'b1;
          end else begin
            tx_state_d = StIdle;
            ready_d    = 1'b1;
          end
        end
        default: begin
          tx_state_d = StIdle;
          tx_line_d  = 1'b1;
          ready_d    = 1'b1;
        end
      endcase
    end
  end

  // TX state registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tx_state_q  <= StIdle;
      tx_cnt_q    <= 16'd0;
      tx_bit_q    <= 3'd0;
      tx_byte_q   <= 8'h00;
      tx_div_q    <= 16'd16;
      tx_par_en_q <= 1'b0;
      tx_odd_q    <= 1'b0;
      tx_two_q    <= 1'b0;
      tx_stop2_q  <= 1'b0;
      tx_line_q   <= 1'b1;
      ready_q     <= 1'b1;
    end else begin
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_byte_q   <= tx_byte_d;
      tx_div_q    <= tx_div_d;
      tx_par_en_q <= tx_par_en_d;
      tx_odd_q    <= tx_odd_d;
      tx_two_q    <= tx_two_d;
      tx_stop2_q  <= tx_stop2_d;
      tx_line_q   <= tx_line_d;
      ready_q     <= ready_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic        sync1_q, sync2_q, sync3_q;
  logic        rx_s, rx_fall;
  logic [2:0]  rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_byte_q, rx_byte_d;
  logic [15:0] rx_div_q, rx_div_d;
  logic        rx_par_en_q, rx_par_en_d;
  logic        rx_odd_q, rx_odd_d;
  logic        rx_par_bad_q, rx_par_bad_d;
  logic        rx_valid_q, rx_valid_d;
  logic        rx_error_q, rx_error_d;
  logic        rx_done, rx_bad;
  logic [15:0] rx_last, rx_mid;
  logic [8:0]  data_q, data_d;

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
    end else begin
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rx_s    = sync2_q;
  assign rx_fall = sync3_q & ~sync2_q;
  assign rx_last = rx_div_q - 16'd1;
  // The edge is seen about two clocks late; the start wait is shortened by two
  // so sampling lands at DIV/2 into each bit on the wire.
  assign rx_mid  = (rx_div_q >> 1) - 16'd2;

  // RX next state.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_byte_d    = rx_byte_q;
    rx_div_d     = rx_div_q;
    rx_par_en_d  = rx_par_en_q;
    rx_odd_d     = rx_odd_q;
    rx_par_bad_d = rx_par_bad_q;
    rx_valid_d   = rx_valid_q;
    rx_error_d   = rx_error_q;
    rx_done      = 1'b0;
    rx_bad       = 1'b0;
    case (rx_state_q)
      StIdle: begin
        if (rx_fall) begin
          rx_state_d   = StStart;
          rx_cnt_d     = 16'd0;
          rx_div_d     = div_eff;
          rx_par_en_d  = lcr_q[3];
          rx_odd_d     = lcr_q[1];
          rx_par_bad_d = 1'b0;
          rx_valid_d   = 1'b0;
          rx_error_d   = 1'b0;
        end
      end
      StStart: begin
        if (rx_cnt_q == rx_mid) begin
          rx_cnt_d   = 16'd0;
          rx_bit_d   = 3'd0;
          // A start bit that is high again at mid-bit was a glitch.
          rx_state_d = rx_s ? StIdle : StData;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      StData: begin
        if (rx_cnt_q == rx_last) begin
          rx_cnt_d  = 16'd0;
          rx_byte_d = {rx_s, rx_byte_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = rx_par_en_q ? StParity : StStop;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      StParity: begin
        if (rx_cnt_q == rx_last) begin
          rx_cnt_d     = 16'd0;
          rx_par_bad_d = rx_s != (^rx_byte_q ^ rx_odd_q);
          rx_state_d   = StStop;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (rx_cnt_q == rx_last) begin
          rx_cnt_d   = 16'd0;
          rx_state_d = StIdle;
          rx_done    = 1'b1;
          rx_bad     = ~rx_s | rx_par_bad_q;
          rx_valid_d = ~rx_bad;
          rx_error_d = rx_bad;
        end else begin
          rx_cnt_d = rx_cnt_q + 16'd1;
        end
      end
      default: rx_state_d = StIdle;
    endcase
  end

  // Read data / RX data; a completing frame takes priority over a read.
  always_comb begin
    data_d = data_q;
    if (!i_rs_n) data_d = {1'b0, reg_rd};
    if (rx_done) data_d = {rx_bad, rx_byte_q};
  end

  // RX state and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_state_q   <= StIdle;
      rx_cnt_q     <= 16'd0;
      rx_bit_q     <= 3'd0;
      rx_byte_q    <= 8'h00;
      rx_div_q     <= 16'd16;
      rx_par_en_q  <= 1'b0;
      rx_odd_q     <= 1'b0;
      rx_par_bad_q <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_error_q   <= 1'b0;
      data_q       <= 9'h000;
    end else begin
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_byte_q    <= rx_byte_d;
      rx_div_q     <= rx_div_d;
      rx_par_en_q  <= rx_par_en_d;
      rx_odd_q     <= rx_odd_d;
      rx_par_bad_q <= rx_par_bad_d;
      rx_valid_q   <= rx_valid_d;
      rx_error_q   <= rx_error_d;
      data_q       <= data_d;
    end
  end

  assign o_data     = data_q;
  assign o_tx       = tx_line_q;
  assign o_ready    = ready_q;
  assign o_rx_valid = rx_valid_q;
  assign o_rx_error = rx_error_q;

endmodule

// File: tb/tb_uart_top.sv
// Self-checking bench for uart_top: register vector table, loopback frames
// against a frame-length/byte model, and hand-driven RX corner cases.
module tb_uart_top;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_request_tx;
  logic       i_ws_n;
  logic       i_rs_n;
  logic [3:0] i_addr;
  logic [8:0] i_data;
  logic [8:0] o_data;
  logic       i_rx;
  logic       o_tx;
  logic       o_ready;
  logic       o_rx_error;
  logic       o_rx_valid;

  logic loop_en;
  logic rx_drv;
  int   checks   = 0;
  int   failures = 0;

`ifdef UART_PARITY_EN
  localparam bit HasParity = 1'b1;
`else
  localparam bit HasParity = 1'b0;
`endif

  assign i_rx = loop_en ? o_tx : rx_drv;

  always #5 i_clk = ~i_clk;

  uart_top dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_request_tx (i_request_tx),
    .i_ws_n       (i_ws_n),
    .i_rs_n       (i_rs_n),
    .i_addr       (i_addr),
    .i_data       (i_data),
    .o_data       (o_data),
    .i_rx         (i_rx),
    .o_tx         (o_tx),
    .o_ready      (o_ready),
    .o_rx_error   (o_rx_error),
    .o_rx_valid   (o_rx_valid)
  );

  typedef struct {
    logic       ws_n;
    logic       rs_n;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       chk;
    logic [8:0] exp;
  } vec_t;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] v);
    i_ws_n = 1'b0;
    i_addr = a;
    i_data = {1'b0, v};
    tick();
    i_ws_n = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a);
    i_rs_n = 1'b0;
    i_addr = a;
    tick();
    i_rs_n = 1'b1;
  endtask

  // Sends one loopback frame and checks its length and the received byte.
  // act_kind: 0 none, 1 write DIVL=act_val at cycle act_at, 2 extra request.
  task automatic run_frame(input logic [7:0] b, input int exp_len, input string tag,
                           input int act_at, input int act_kind, input logic [7:0] act_val);
    int n;
    i_data       = {1'b0, b};
    i_request_tx = 1'b1;
    tick();
    i_request_tx = 1'b0;
    n = 0;
    while (o_ready == 1'b0 && n < 4000) begin
      i_ws_n       = 1'b1;
      i_request_tx = 1'b0;
      if (n == act_at && act_kind == 1) begin
        i_ws_n = 1'b0;
        i_addr = 4'h0;
        i_data = {1'b0, act_val};
      end
      if (n == act_at && act_kind == 2) begin
        i_request_tx = 1'b1;
        i_data       = {1'b0, act_val};
      end
      if (n == exp_len / 2) check({tag, "_mid_valid"}, {31'd0, o_rx_valid}, 32'd0);
      tick();
      n++;
    end
    i_ws_n       = 1'b1;
    i_request_tx = 1'b0;
    check({tag, "_len"}, n, exp_len);
    check({tag, "_valid"}, {31'd0, o_rx_valid}, 32'd1);
    check({tag, "_error"}, {31'd0, o_rx_error}, 32'd0);
    check({tag, "_data"}, {23'd0, o_data}, {24'd0, b});
  endtask

  // Drives start, data and optional parity bits onto i_rx.
  task automatic drive_head(input logic [7:0] b, input logic use_par, input logic par_bit,
                            input int div);
    rx_drv = 1'b0;
    repeat (div) tick();
    for (int i = 0; i < 8; i++) begin
      rx_drv = b[i];
      repeat (div) tick();
    end
    if (use_par) begin
      rx_drv = par_bit;
      repeat (div) tick();
    end
  endtask

  task automatic drive_tail(input logic stop_bit, input int div);
    rx_drv = stop_bit;
    repeat (div) tick();
    rx_drv = 1'b1;
    repeat (2 * div) tick();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[15];
    int   div, eff, two, par, odd, len, k;
    logic [7:0] b;
    logic bad;

    i_rst_n      = 1'b0;
    i_request_tx = 1'b0;
    i_ws_n       = 1'b1;
    i_rs_n       = 1'b1;
    i_addr       = 4'h0;
    i_data       = 9'h000;
    loop_en      = 1'b1;
    rx_drv       = 1'b1;

    // Reset state.
    repeat (25) tick();
    i_rst_n = 1'b1;
    tick();
    check("rst_data", {23'd0, o_data}, 32'h0);
    check("rst_tx", {31'd0, o_tx}, 32'd1);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_rx_error", {31'd0, o_rx_error}, 32'd0);
    check("rst_rx_valid", {31'd0, o_rx_valid}, 32'd0);

    // Register access table.
    vecs[0]  = '{1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 9'h010};
    vecs[1]  = '{1'b1, 1'b0, 4'h1, 8'h00, 1'b1, 9'h000};
    vecs[2]  = '{1'b1, 1'b0, 4'h7, 8'h00, 1'b1, 9'h000};
    vecs[3]  = '{1'b0, 1'b1, 4'h3, 8'hFF, 1'b0, 9'h000};
    vecs[4]  = '{1'b1, 1'b0, 4'h3, 8'h00, 1'b1, 9'h000};
    vecs[5]  = '{1'b0, 1'b1, 4'h7, 8'hFF, 1'b0, 9'h000};
    vecs[6]  = '{1'b1, 1'b0, 4'h7, 8'h00, 1'b1, HasParity ? 9'h0FF : 9'h0F5};
    vecs[7]  = '{1'b0, 1'b1, 4'h7, 8'h00, 1'b0, 9'h000};
    vecs[8]  = '{1'b1, 1'b0, 4'h7, 8'h00, 1'b1, 9'h000};
    vecs[9]  = '{1'b0, 1'b1, 4'h1, 8'h01, 1'b0, 9'h000};
    vecs[10] = '{1'b1, 1'b0, 4'h1, 8'h00, 1'b1, 9'h001};
    vecs[11] = '{1'b0, 1'b1, 4'h1, 8'h00, 1'b0, 9'h000};
    vecs[12] = '{1'b0, 1'b1, 4'h0, 8'h08, 1'b0, 9'h000};
    vecs[13] = '{1'b1, 1'b0, 4'h0, 8'h00, 1'b1, 9'h008};
    vecs[14] = '{1'b1, 1'b0, 4'hF, 8'h00, 1'b1, 9'h000};
    for (int i = 0; i < 15; i++) begin
      i_ws_n = vecs[i].ws_n;
      i_rs_n = vecs[i].rs_n;
      i_addr = vecs[i].addr;
      i_data = {1'b0, vecs[i].wdata};
      tick();
      i_ws_n = 1'b1;
      i_rs_n = 1'b1;
      if (vecs[i].chk) check($sformatf("reg_vec%0d", i), {23'd0, o_data}, {23'd0, vecs[i].exp});
    end

    // Busy request is ignored; 8 clocks per bit, 10 bits.
    run_frame(8'h11, 80, "busy", 10, 2, 8'h22);
    bad = 1'b0;
    repeat (16) begin
      if (o_tx !== 1'b1 || o_ready !== 1'b1) bad = 1'b1;
      tick();
    end
    check("busy_no_second_frame", {31'd0, bad}, 32'd0);

    // Divider write mid-frame only affects the next frame.
    run_frame(8'h6B, 80, "divchg", 20, 1, 8'h06);
    run_frame(8'h94, 60, "div6", -1, 0, 8'h00);

    // Parity enabled with two stop bits.
    wr(4'h7, 8'h09);
    run_frame(8'h5A, HasParity ? 72 : 66, "lcr09", -1, 0, 8'h00);
    wr(4'h7, 8'h00);

    // Divider below the minimum is clamped to 4.
    wr(4'h0, 8'h00);
    run_frame(8'hC3, 40, "div0", -1, 0, 8'h00);

    // Randomized loopback frames against the frame-length model.
    for (int r = 0; r < 5; r++) begin
      div = $urandom_range(2, 12);
      two = $urandom_range(0, 1);
      par = $urandom_range(0, 1);
      odd = $urandom_range(0, 1);
      b   = 8'($urandom_range(0, 255));
      wr(4'h0, 8'(div));
      wr(4'h7, {4'b0, par[0], 1'b0, odd[0], two[0]});
      eff = (div < 4) ? 4 : div;
      len = eff * (10 + (HasParity ? par : 0) + two);
      run_frame(b, len, $sformatf("rand%0d", r), -1, 0, 8'h00);
    end

    // Hand-driven receive cases at 8 clocks per bit.
    wr(4'h0, 8'h08);
    wr(4'h1, 8'h00);
    wr(4'h7, 8'h00);
    loop_en = 1'b0;
    rx_drv  = 1'b1;
    repeat (20) tick();

    drive_head(8'h3C, 1'b0, 1'b0, 8);
    drive_tail(1'b0, 8);
    check("ferr_error", {31'd0, o_rx_error}, 32'd1);
    check("ferr_valid", {31'd0, o_rx_valid}, 32'd0);
    check("ferr_data", {23'd0, o_data}, 32'h13C);

    // RX completion and a read in the same cycle: RX data wins.
    i_rs_n = 1'b0;
    i_addr = 4'h0;
    drive_head(8'hA5, 1'b0, 1'b0, 8);
    rx_drv = 1'b1;
    k = 0;
    while (o_rx_valid == 1'b0 && o_rx_error == 1'b0 && k < 16) begin
      tick();
      k++;
    end
    i_rs_n = 1'b1;
    check("collide_valid", {31'd0, o_rx_valid}, 32'd1);
    check("collide_data", {23'd0, o_data}, 32'h0A5);
    repeat (16) tick();

    // Short glitch: start is dropped, flags cleared, data kept.
    rx_drv = 1'b0;
    repeat (2) tick();
    rx_drv = 1'b1;
    repeat (24) tick();
    check("glitch_valid", {31'd0, o_rx_valid}, 32'd0);
    check("glitch_error", {31'd0, o_rx_error}, 32'd0);
    check("glitch_data", {23'd0, o_data}, 32'h0A5);

    drive_head(8'h5C, 1'b0, 1'b0, 8);
    drive_tail(1'b1, 8);
    check("recover_valid", {31'd0, o_rx_valid}, 32'd1);
    check("recover_data", {23'd0, o_data}, 32'h05C);

`ifdef UART_PARITY_EN
    wr(4'h7, 8'h08);
    drive_head(8'h01, 1'b1, 1'b0, 8);
    drive_tail(1'b1, 8);
    check("perr_error", {31'd0, o_rx_error}, 32'd1);
    check("perr_data", {23'd0, o_data}, 32'h101);
    wr(4'h7, 8'h0A);
    drive_head(8'h03, 1'b1, 1'b1, 8);
    drive_tail(1'b1, 8);
    check("podd_valid", {31'd0, o_rx_valid}, 32'd1);
    check("podd_data", {23'd0, o_data}, 32'h003);
    wr(4'h7, 8'h00);
`endif

    // Asynchronous reset in the middle of a frame.
    loop_en = 1'b1;
    drive_head(8'hFF, 1'b0, 1'b0, 0);
    i_data       = 9'h000;
    i_request_tx = 1'b1;
    tick();
    i_request_tx = 1'b0;
    repeat (4) tick();
    check("pre_rst_tx_low", {31'd0, o_tx}, 32'd0);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_tx", {31'd0, o_tx}, 32'd1);
    check("arst_ready", {31'd0, o_ready}, 32'd1);
    check("arst_data", {23'd0, o_data}, 32'h0);
    check("arst_valid", {31'd0, o_rx_valid}, 32'd0);
    repeat (3) tick();
    i_rst_n = 1'b1;
    tick();
    check("rel_ready", {31'd0, o_ready}, 32'd1);
    bad = 1'b0;
    repeat (200) begin
      if (o_tx !== 1'b1 || o_rx_valid !== 1'b0 || o_rx_error !== 1'b0) bad = 1'b1;
      tick();
    end
    check("no_partial_output", {31'd0, bad}, 32'd0);
    rd(4'h0);
    check("rst_divl", {23'd0, o_data}, 32'h010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
